// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for the 8-digit seven-segment scan
//               controller: hex segment table, blanking/select idle
//               patterns, digit count and scan FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  // Number of digits in the display
  localparam int NUM_DIG = 8;

  // All segments dark (active-low) and no digit selected (active-low)
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  // Active-low a..g patterns (bit 0 = a, bit 6 = g) for hex 0..F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  // Scan FSM state encoding
  localparam int STATE_W = 1;
  typedef logic [STATE_W-1:0] seg_state_t;
  localparam seg_state_t ST_GUARD = 1'b0;
  localparam seg_state_t ST_DWELL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
// ============================================================================
// Module      : seg_decode
// Description : Combinational hex + decimal-point to active-low segment
//               decoder. seg[6:0] = a..g, seg[7] = dp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup for a..g; dp is inverted onto the active-low bit 7
  always_comb begin
    seg = {~dp, SEG_HEX[hex]};
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed 8-digit seven-segment scan controller with a
//               host-written shadow buffer and a frame-synchronous commit
//               into the displayed (active) buffer. Each digit is driven for
//               DWELL_CYC clocks, separated by GUARD_CYC all-off clocks.
//               Optional build macro SEG_LZB_EN enables leading-zero
//               blanking (digits 7 downward, digit 0 never blanked).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter logic [24:0] DWELL_CYC = 25'd50_000,
  parameter logic [24:0] GUARD_CYC = 25'd500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       wr_commit,
  output logic [7:0] sel,
  output logic [7:0] seg,
  output logic       frame_done
);

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [4:0]  r_shadow [NUM_DIG];
  logic [4:0]  r_active [NUM_DIG];
  logic        r_commit_pending;

  seg_state_t  r_state;
  seg_state_t  w_state_nxt;
  logic [24:0] r_cnt;
  logic [24:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;

  logic [7:0]  r_sel;
  logic [7:0]  r_seg;
  logic        r_frame_done;

  logic        w_frame_end;
  logic [7:0]  w_sel_nxt;
  logic [7:0]  w_seg_nxt;
  logic [4:0]  w_cur;
  logic [7:0]  w_dec_seg;
  logic        w_blank;

  // A commit blocks further host traffic until the frame boundary copies it
  assign wr_ready   = ~r_commit_pending;
  assign sel        = r_sel;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  // --------------------------------------------------------------------------
  // Decoder for the digit currently addressed by the scan index
  // --------------------------------------------------------------------------
  assign w_cur = r_active[r_idx];

  seg_decode u_decode (
    .hex (w_cur[3:0]),
    .dp  (w_cur[4]),
    .seg (w_dec_seg)
  );

  // --------------------------------------------------------------------------
  // Leading-zero blanking
  // --------------------------------------------------------------------------
`ifdef SEG_LZB_EN
  logic [NUM_DIG-1:0] w_blank_mask;
  logic               w_lz_run;

  // Walk from the leftmost digit down; blanking stops at the first digit
  // that is non-zero or carries a decimal point. Digit 0 is never blanked.
  always_comb begin
    w_blank_mask = '0;
    w_lz_run     = 1'b1;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      w_lz_run        = w_lz_run & (r_active[i] == 5'd0);
      w_blank_mask[i] = w_lz_run;
    end
  end

  assign w_blank = w_blank_mask[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------

  // State register: phase, cycle counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: count out each phase, advance the digit after its dwell
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 25'd1;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_GUARD: begin
        if (r_cnt == GUARD_CYC - 25'd1) begin
          w_state_nxt = ST_DWELL;
          w_cnt_nxt   = '0;
        end
      end
      ST_DWELL: begin
        if (r_cnt == DWELL_CYC - 25'd1) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_GUARD;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Output decode: select/segment values for the next registered update
  always_comb begin
    w_frame_end = 1'b0;
    w_sel_nxt   = SEL_OFF;
    w_seg_nxt   = SEG_OFF;
    if (r_state == ST_DWELL) begin
      w_sel_nxt   = ~(8'd1 << r_idx);
      w_seg_nxt   = w_blank ? SEG_OFF : w_dec_seg;
      w_frame_end = (r_cnt == DWELL_CYC - 25'd1) && (r_idx == 3'd7);
    end
  end

  // Registered outputs so sel/seg cannot glitch across two digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel        <= SEL_OFF;
      r_seg        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  // --------------------------------------------------------------------------
  // Host buffers
  // --------------------------------------------------------------------------

  // Shadow writes, commit request, and the frame-boundary copy to active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_commit_pending <= 1'b0;
    end else begin
      if (wr_valid && wr_ready) begin
        r_shadow[wr_addr] <= wr_data;
      end
      // Shadow is frozen while pending, so the copy sees the committed image
      if (w_frame_end && r_commit_pending) begin
        for (int i = 0; i < NUM_DIG; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_commit_pending <= 1'b0;
      end else if (wr_commit && wr_ready) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl with
//               DWELL_CYC = 4, GUARD_CYC = 1 (40-clock frame). Honours
//               SEG_LZB_EN when the bundle is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_commit;
  logic [7:0] sel;
  logic [7:0] seg;
  logic       frame_done;

  int n_tests;
  int n_fail;

  // Expected segment value per digit for the frame walks
  logic [7:0] exp_seg [8];

  seg_scan_ctrl #(
    .DWELL_CYC (25'd4),
    .GUARD_CYC (25'd1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until frame_done is seen; an expired budget is a failure
  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_frame_done: frame_done not seen within 100 clocks");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_commit = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (sel !== 8'hFF) begin n_fail++; $display("FAIL reset_sel: got %h want ff", sel); end
    n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    rst = 1'b0;
    step();
    n_tests++; if (sel !== 8'hFF) begin n_fail++; $display("FAIL rel_guard_sel: got %h want ff", sel); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (sel !== 8'hFE) begin n_fail++; $display("FAIL rel_dwell0_sel[%0d]: got %h want fe", i, sel); end
      n_tests++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL rel_dwell0_seg[%0d]: got %h want c0", i, seg); end
    end
    step();
    n_tests++; if (sel !== 8'hFF) begin n_fail++; $display("FAIL rel_guard1_sel: got %h want ff", sel); end
    step();
    n_tests++; if (sel !== 8'hFD) begin n_fail++; $display("FAIL rel_dwell1_sel: got %h want fd", sel); end
  endtask

  task automatic test_full_frame();
    bit ok;
    logic [7:0] es;
    logic       efd;
    wait_fd(ok);
    if (ok) begin
      for (int d = 0; d < 8; d++) begin
        for (int p = 0; p < 5; p++) begin
          step();
          es  = (p == 0) ? 8'hFF : ~(8'd1 << d);
          efd = (d == 7) && (p == 4);
          n_tests++; if (sel !== es) begin n_fail++; $display("FAIL frame_sel d%0d p%0d: got %h want %h", d, p, sel, es); end
          n_tests++; if (frame_done !== efd) begin n_fail++; $display("FAIL frame_fd d%0d p%0d: got %b want %b", d, p, frame_done, efd); end
        end
      end
    end
  endtask

  task automatic test_commit();
    bit ok;
    logic [7:0] es;
    logic [7:0] eg;
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 5'h1A; wr_commit = 1'b1;
    step();
    wr_valid = 1'b0; wr_commit = 1'b0;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready_drop: got %b want 0", wr_ready); end
    // Attempted write while busy must be dropped
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 5'h07;
    step();
    wr_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (frame_done === 1'b1) begin ok = 1'b1; break; end
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready_hold: got %b want 0", wr_ready); end
      step();
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL commit_frame_done: got timeout want pulse"); end
    if (ok) begin
      n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL commit_ready_back: got %b want 1", wr_ready); end
`ifdef SEG_LZB_EN
      exp_seg = '{8'hC0, 8'hC0, 8'hC0, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
      exp_seg = '{8'hC0, 8'hC0, 8'hC0, 8'h08, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
      for (int d = 0; d < 8; d++) begin
        for (int p = 0; p < 5; p++) begin
          step();
          es = (p == 0) ? 8'hFF : ~(8'd1 << d);
          eg = (p == 0) ? 8'hFF : exp_seg[d];
          n_tests++; if (sel !== es) begin n_fail++; $display("FAIL commit_sel d%0d p%0d: got %h want %h", d, p, sel, es); end
          n_tests++; if (seg !== eg) begin n_fail++; $display("FAIL commit_seg d%0d p%0d: got %h want %h", d, p, seg, eg); end
        end
      end
    end
  endtask

  task automatic test_ignored_write();
    bit ok;
    // A fresh commit must still not reveal the dropped write of 7 to digit 0
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready_drop: got %b want 0", wr_ready); end
    wait_fd(ok);
    if (ok) begin
      for (int d = 0; d < 8; d++) begin
        for (int p = 0; p < 5; p++) begin
          step();
          if (p != 0 && (d == 0 || d == 3)) begin
            n_tests++;
            if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL ign_seg d%0d p%0d: got %h want %h", d, p, seg, exp_seg[d]); end
          end
        end
      end
    end
  endtask

  task automatic test_lzb();
    bit ok;
    logic [7:0] eg;
    // Active image 7..0 = 0,0,0,0,0,1,0,0
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 5'h00;
    step();
    wr_addr = 3'd2; wr_data = 5'h01; wr_commit = 1'b1;
    step();
    wr_valid = 1'b0; wr_commit = 1'b0;
    wait_fd(ok);
`ifdef SEG_LZB_EN
    exp_seg = '{8'hC0, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_seg = '{8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    if (ok) begin
      for (int d = 0; d < 8; d++) begin
        for (int p = 0; p < 5; p++) begin
          step();
          eg = (p == 0) ? 8'hFF : exp_seg[d];
          n_tests++; if (seg !== eg) begin n_fail++; $display("FAIL lzb_seg d%0d p%0d: got %h want %h", d, p, seg, eg); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_commit();
    bit ok;
    logic [7:0] eg;
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 5'h0F; wr_commit = 1'b1;
    step();
    wr_valid = 1'b0; wr_commit = 1'b0;
    step();
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmc_pending: got %b want 0", wr_ready); end
    rst = 1'b1;
    #1;
    n_tests++; if (sel !== 8'hFF) begin n_fail++; $display("FAIL rmc_sel: got %h want ff", sel); end
    n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL rmc_seg: got %h want ff", seg); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready: got %b want 1", wr_ready); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rmc_fd: got %b want 0", frame_done); end
    step();
    rst = 1'b0;
    step();
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready_rel: got %b want 1", wr_ready); end
    wait_fd(ok);
`ifdef SEG_LZB_EN
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp_seg = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    if (ok) begin
      n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready_fd: got %b want 1", wr_ready); end
      for (int d = 0; d < 8; d++) begin
        for (int p = 0; p < 5; p++) begin
          step();
          eg = (p == 0) ? 8'hFF : exp_seg[d];
          n_tests++; if (seg !== eg) begin n_fail++; $display("FAIL rmc_seg d%0d p%0d: got %h want %h", d, p, seg, eg); end
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_full_frame();
    test_commit();
    test_ignored_write();
    test_lzb();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
